// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: streams a WIDTH-bit operand pair LSB first,
// threads the slice carry/borrow back into cin and reassembles the result.
module serial_alu_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [3:0]       slice_opcode,
  input  logic [1:0]       slice_out,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while busy=0 (IDLE or the single DONE cycle);
  // busy stays high for WIDTH cycles, then done pulses for one cycle with result valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_next;

  assign res_next  = {slice_out[0], res_sr[WIDTH-1:1]};
  assign slice_a   = (state == RUN) & a_sr[0];
  assign slice_b   = (state == RUN) & b_sr[0];
  assign slice_cin = (state == RUN) & carry;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      carry_out    <= 1'b0;
      zero         <= 1'b0;
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      slice_opcode <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr         <= op_a;
            b_sr         <= op_b;
            slice_opcode <= opcode;
            cnt          <= '0;
            carry        <= 1'b0;
            busy         <= 1'b1;
            state        <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_sr <= res_next;
          carry  <= slice_out[1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CNT_W'(1);
          // The last bit is captured straight into the visible outputs on this edge.
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= res_next;
            carry_out <= slice_out[1];
            zero      <= (res_next == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl: WIDTH=8 vectors with hand-computed results,
// plus a WIDTH=64 add/sub sweep against an arithmetic reference.
module tb_serial_alu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- WIDTH=8 instance ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] opc8 = '0;
  logic       busy8, done8, cout8, zero8, sa8, sb8, scin8;
  logic [7:0] res8;
  logic [3:0] sop8;
  logic [1:0] sout8, st8;

  // ---------------- WIDTH=64 instance ----------------
  logic        start64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic [3:0]  opc64 = '0;
  logic        busy64, done64, cout64, zero64, sa64, sb64, scin64;
  logic [63:0] res64;
  logic [3:0]  sop64;
  logic [1:0]  sout64, st64;

  function automatic logic [1:0] slice_model(input logic a, input logic b, input logic cin,
                                             input logic [3:0] op);
    case (op)
      4'b0000: return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
      4'b1000: return {(~a & b) | (~a & cin) | (b & cin), a ^ b ^ cin};
      default: return 2'b00;
    endcase
  endfunction

  assign sout8  = slice_model(sa8, sb8, scin8, sop8);
  assign sout64 = slice_model(sa64, sb64, scin64, sop64);

  serial_alu_ctrl #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8), .opcode(opc8),
    .busy(busy8), .done(done8), .result(res8), .carry_out(cout8), .zero(zero8),
    .slice_a(sa8), .slice_b(sb8), .slice_cin(scin8), .slice_opcode(sop8),
    .slice_out(sout8), .dbg_state(st8)
  );

  serial_alu_ctrl #(.WIDTH(64), .CNT_W(7)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .op_a(a64), .op_b(b64), .opcode(opc64),
    .busy(busy64), .done(done64), .result(res64), .carry_out(cout64), .zero(zero64),
    .slice_a(sa64), .slice_b(sb64), .slice_cin(scin64), .slice_opcode(sop64),
    .slice_out(sout64), .dbg_state(st64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done64(output int n);
    n = 0;
    while (done64 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] opc, input logic [7:0] exp_res,
                     input logic exp_c, input logic exp_z);
    int n;
    a8 = a; b8 = b; opc8 = opc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b;
    wait_done8(n);
    check({tag, "_lat"}, 64'(n), 64'd8);
    check({tag, "_busy"}, 64'(busy8), 64'd0);
    check({tag, "_res"}, 64'(res8), 64'(exp_res));
    check({tag, "_cout"}, 64'(cout8), 64'(exp_c));
    check({tag, "_zero"}, 64'(zero8), 64'(exp_z));
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic sub);
    int n;
    logic [64:0] ref_v;
    a64 = a; b64 = b; opc64 = sub ? 4'b1000 : 4'b0000; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    if (sub) ref_v = {(a < b) ? 1'b1 : 1'b0, a - b};
    else     ref_v = {1'b0, a} + {1'b0, b};
    wait_done64(n);
    check("w64_lat", 64'(n), 64'd64);
    check("w64_res", res64, ref_v[63:0]);
    check("w64_cout", 64'(ref_v[64] ^ cout64), 64'd0);
  endtask

  initial begin
    int n;
    int n2;
    // Reset state
    repeat (2) tick();
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_res", 64'(res8), 64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    check("rst_zero", 64'(zero8), 64'd0);
    check("rst_state", 64'(st8), 64'd0);
    check("rst_sop", 64'(sop8), 64'd0);
    #3 rst_n = 1'b1;
    tick();

    op8("add1", 8'h5A, 8'h3C, 4'b0000, 8'h96, 1'b0, 1'b0);
    tick();
    check("idle_after_done", 64'(done8), 64'd0);
    op8("add_wrap", 8'hFF, 8'h01, 4'b0000, 8'h00, 1'b1, 1'b1);
    op8("sub1", 8'h10, 8'h01, 4'b1000, 8'h0F, 1'b0, 1'b0);
    op8("sub_borrow", 8'h01, 8'h02, 4'b1000, 8'hFF, 1'b1, 1'b0);
    op8("bad_opc", 8'hAA, 8'h55, 4'b0011, 8'h00, 1'b0, 1'b1);

    // Start mid-RUN with different operands is ignored
    a8 = 8'h12; b8 = 8'h34; opc8 = 4'b0000; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    a8 = 8'hF0; b8 = 8'hF0; opc8 = 4'b1000; start8 = 1'b1;
    tick();
    tick();
    start8 = 1'b0;
    wait_done8(n);
    check("midstart_lat", 64'(n + 5), 64'd8);
    check("midstart_res", 64'(res8), 64'h46);
    check("midstart_cout", 64'(cout8), 64'd0);
    tick();

    // Back-to-back: start held high through DONE
    a8 = 8'h80; b8 = 8'h80; opc8 = 4'b0000; start8 = 1'b1;
    tick();
    a8 = 8'h30; b8 = 8'h05; opc8 = 4'b1000;
    wait_done8(n);
    check("b2b1_lat", 64'(n), 64'd8);
    check("b2b1_res", 64'(res8), 64'h00);
    check("b2b1_cout", 64'(cout8), 64'd1);
    check("b2b1_zero", 64'(zero8), 64'd1);
    tick();
    start8 = 1'b0;
    check("b2b_no_idle", 64'(busy8), 64'd1);
    wait_done8(n2);
    check("b2b_spacing", 64'(n2 + 1), 64'd9);
    check("b2b2_res", 64'(res8), 64'h2B);
    check("b2b2_cout", 64'(cout8), 64'd0);
    check("b2b2_zero", 64'(zero8), 64'd0);
    tick();

    // Asynchronous reset partway through an add
    a8 = 8'h77; b8 = 8'h11; opc8 = 4'b0000; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy8), 64'd0);
    check("arst_done", 64'(done8), 64'd0);
    check("arst_res", 64'(res8), 64'd0);
    check("arst_cout", 64'(cout8), 64'd0);
    check("arst_zero", 64'(zero8), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    repeat (12) tick();
    check("arst_no_done", 64'(done8), 64'd0);
    op8("after_rst", 8'hC8, 8'h64, 4'b0000, 8'h2C, 1'b1, 1'b0);

    // WIDTH=64 sweep: fixed corners then random add/sub
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    op64(64'h0, 64'h1, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      op64({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
